// File: rtl/slip_count_reg_if.sv
// Control, data and status signals of one counter slice.
// The parent drives the master side; the counter slice is the slave.
interface slip_count_reg_if #(
    parameter int WIDTH = 16
);
    logic             CLEAR;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             CIN;
    logic             RELOAD_EN;
    logic [WIDTH-1:0] Q;
    logic             COUT;
    logic             TC;

    modport master (
        output CLEAR, LOAD, D, CIN, RELOAD_EN,
        input  Q, COUT, TC
    );

    modport slave (
        input  CLEAR, LOAD, D, CIN, RELOAD_EN,
        output Q, COUT, TC
    );
endinterface

// File: rtl/slip_count_reg.sv
// Loadable, cascadable up-counter slice built from a half-adder ripple chain, with optional modulo reload.
// Latency: Q and TC update 1 cycle after the controlling edge; COUT is combinational from CIN and Q.
// Backpressure: none; CIN acts as the count enable, and CLEAR and LOAD take priority over counting.
module slip_count_reg #(
    parameter int WIDTH = 16
) (
    input  logic              MasterClock,
    input  logic              RESET,
    slip_count_reg_if.slave   bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = bus.CIN;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = q_q[i] ^ carry[i];
            carry[i+1] = q_q[i] & carry[i];
        end
    end

    // A carry out of the top bit is the wrap condition: CIN high with Q all-ones.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (bus.CLEAR) begin
            q_d = '0;
        end else if (bus.LOAD) begin
            q_d = bus.D;
        end else if (carry[WIDTH]) begin
            q_d  = bus.RELOAD_EN ? bus.D : '0;
            tc_d = 1'b1;
        end else begin
            q_d = sum;
        end
    end

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.TC   = tc_q;
    assign bus.COUT = carry[WIDTH];
endmodule
